// File: rtl/sram_bus_master.sv
// sram_bus_master
//   Single-request master for an asynchronous byte-wide SRAM. Each accepted
//   host request goes through the phases SETUP (address/chip-enable settle),
//   ACCESS (strobe low for WAIT_CYCLES cycles) and HOLD (strobe released,
//   bus held). A one-cycle response pulse is raised during HOLD.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          host request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata  request fields, latched on accept
//   rsp_valid, rsp_rdata         completion pulse and read data (held)
//   ce_n, oe_n, we_n             SRAM strobes, active low
//   address, data_out, data_oe   SRAM address, write data and its drive enable
//   data_in                      SRAM read data
//
// Every output, including req_ready, comes straight from a flop. The flops
// are loaded with the values that belong to the state being entered, so
// nothing combinational sits between an input pin and an output pin.

module sram_bus_master #(
    parameter int MEM_SIZE    = 65536,
    parameter int WAIT_CYCLES = 2,
    localparam int AW         = $clog2(MEM_SIZE)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [7:0]    req_wdata,
    output logic          rsp_valid,
    output logic [7:0]    rsp_rdata,
    output logic          ce_n,
    output logic          oe_n,
    output logic          we_n,
    output logic [AW-1:0] address,
    output logic [7:0]    data_out,
    input  logic [7:0]    data_in,
    output logic          data_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [3:0]    wait_cnt_reg, wait_cnt_next;
    logic          we_lat_reg, we_lat_next;
    logic          req_ready_reg, req_ready_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [7:0]    rsp_rdata_reg, rsp_rdata_next;
    logic          ce_n_reg, ce_n_next;
    logic          oe_n_reg, oe_n_next;
    logic          we_n_reg, we_n_next;
    logic [AW-1:0] address_reg, address_next;
    logic [7:0]    data_out_reg, data_out_next;
    logic          data_oe_reg, data_oe_next;
    logic          accept;

    // req_ready_reg is high exactly when the FSM sits in IDLE out of reset,
    // so it doubles as the "may accept" qualifier.
    assign accept = req_valid && req_ready_reg;

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        we_lat_next    = we_lat_reg;
        address_next   = address_reg;
        data_out_next  = data_out_reg;
        rsp_rdata_next = rsp_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next    = SETUP;
                    we_lat_next   = req_we;
                    address_next  = req_addr;
                    data_out_next = req_wdata;
                end
            end
            SETUP: begin
                state_next    = ACCESS;
                // Counts remaining ACCESS cycles after the current one.
                wait_cnt_next = 4'(WAIT_CYCLES - 1);
            end
            ACCESS: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = HOLD;
                    // Sample the SRAM while oe_n is still low, on the edge
                    // that ends the strobe.
                    if (!we_lat_reg) begin
                        rsp_rdata_next = data_in;
                    end
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            HOLD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Output levels for the state being entered.
        req_ready_next = (state_next == IDLE);
        ce_n_next      = (state_next == IDLE);
        we_n_next      = !((state_next == ACCESS) &&  we_lat_next);
        oe_n_next      = !((state_next == ACCESS) && !we_lat_next);
        data_oe_next   = (state_next != IDLE) && we_lat_next;
        rsp_valid_next = (state_next == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= 4'd0;
            we_lat_reg    <= 1'b0;
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 8'h00;
            ce_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            we_n_reg      <= 1'b1;
            address_reg   <= '0;
            data_out_reg  <= 8'h00;
            data_oe_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            we_lat_reg    <= we_lat_next;
            req_ready_reg <= req_ready_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            ce_n_reg      <= ce_n_next;
            oe_n_reg      <= oe_n_next;
            we_n_reg      <= we_n_next;
            address_reg   <= address_next;
            data_out_reg  <= data_out_next;
            data_oe_reg   <= data_oe_next;
        end
    end

    assign req_ready = req_ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign ce_n      = ce_n_reg;
    assign oe_n      = oe_n_reg;
    assign we_n      = we_n_reg;
    assign address   = address_reg;
    assign data_out  = data_out_reg;
    assign data_oe   = data_oe_reg;

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master. Three instances (WAIT_CYCLES 2, 1, 15) each drive
// their own behavioural SRAM. Expected responses go into a queue when a
// request is accepted and are popped when rsp_valid shows up.

module tb_sram_bus_master;

    localparam int N  = 3;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid [N];
    logic          req_ready [N];
    logic          req_we    [N];
    logic [AW-1:0] req_addr  [N];
    logic [7:0]    req_wdata [N];
    logic          rsp_valid [N];
    logic [7:0]    rsp_rdata [N];
    logic          ce_n      [N];
    logic          oe_n      [N];
    logic          we_n      [N];
    logic [AW-1:0] address   [N];
    logic [7:0]    data_out  [N];
    logic [7:0]    data_in   [N];
    logic          data_oe   [N];

    always #5 clk = ~clk;

    function automatic int wait_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            logic [7:0] mem [1024];

            sram_bus_master #(
                .MEM_SIZE    (1024),
                .WAIT_CYCLES ((gi == 0) ? 2 : ((gi == 1) ? 1 : 15))
            ) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .req_valid (req_valid[gi]),
                .req_ready (req_ready[gi]),
                .req_we    (req_we[gi]),
                .req_addr  (req_addr[gi]),
                .req_wdata (req_wdata[gi]),
                .rsp_valid (rsp_valid[gi]),
                .rsp_rdata (rsp_rdata[gi]),
                .ce_n      (ce_n[gi]),
                .oe_n      (oe_n[gi]),
                .we_n      (we_n[gi]),
                .address   (address[gi]),
                .data_out  (data_out[gi]),
                .data_in   (data_in[gi]),
                .data_oe   (data_oe[gi])
            );

            // Async SRAM: read data only while selected and output-enabled,
            // otherwise a recognisable junk value stands in for a floating bus.
            assign data_in[gi] = (!ce_n[gi] && !oe_n[gi]) ? mem[address[gi]] : 8'hEE;

            // Write commits on the rising edge of we_n while still selected.
            always @(posedge we_n[gi]) begin
                if (!ce_n[gi]) mem[address[gi]] <= data_out[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        int            k;
        logic          is_read;
        logic [AW-1:0] addr;
        logic [7:0]    wdata;
        logic [7:0]    rdata;
        int            acc_cyc;
    } item_t;

    item_t      sb [$];
    logic [7:0] shadow  [N][1024];
    logic [7:0] last_rd [N];
    int         n_total = 0;
    int         n_pass  = 0;
    int         cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Per-cycle bus monitor (negedge). Only flags and widths here; the main
    // block reads them 1 time unit after the negedge and does the counting.
    // ------------------------------------------------------------------
    int   we_cnt [N], oe_cnt [N], ce_cnt [N], we_w [N], oe_w [N];
    logic bad [N], prev_rsp [N];

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (!rst_n) begin
                we_cnt[k] <= 0; oe_cnt[k] <= 0; ce_cnt[k] <= 0;
                we_w[k] <= 0; oe_w[k] <= 0; bad[k] <= 1'b0; prev_rsp[k] <= 1'b0;
            end else begin
                if (prev_rsp[k]) begin
                    we_w[k] <= 0; oe_w[k] <= 0; bad[k] <= 1'b0;
                end
                prev_rsp[k] <= rsp_valid[k];
                if (!we_n[k]) we_cnt[k] <= we_cnt[k] + 1;
                else if (we_cnt[k] != 0) begin we_w[k] <= we_cnt[k]; we_cnt[k] <= 0; end
                if (!oe_n[k]) oe_cnt[k] <= oe_cnt[k] + 1;
                else if (oe_cnt[k] != 0) begin oe_w[k] <= oe_cnt[k]; oe_cnt[k] <= 0; end
                if (!ce_n[k]) ce_cnt[k] <= ce_cnt[k] + 1;
                else ce_cnt[k] <= 0;
                assert (oe_n[k] || we_n[k]) else begin
                    bad[k] <= 1'b1;
                    $error("FAIL oe_we_overlap inst=%0d observed both low required at most one low", k);
                end
                // Transaction in flight on this instance: bus must be steady.
                if (sb.size() != 0 && sb[0].k == k) begin
                    if (req_ready[k] || ce_n[k] || address[k] !== sb[0].addr) bad[k] <= 1'b1;
                    if (sb[0].is_read && (data_oe[k] || !we_n[k])) bad[k] <= 1'b1;
                    if (!sb[0].is_read && (!data_oe[k] || !oe_n[k] || data_out[k] !== sb[0].wdata))
                        bad[k] <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Tasks
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_reset(input int k);
        check("rst_ce_n", 32'(ce_n[k]), 1);
        check("rst_oe_n", 32'(oe_n[k]), 1);
        check("rst_we_n", 32'(we_n[k]), 1);
        check("rst_address", 32'(address[k]), 0);
        check("rst_data_out", 32'(data_out[k]), 0);
        check("rst_data_oe", 32'(data_oe[k]), 0);
        check("rst_rsp_valid", 32'(rsp_valid[k]), 0);
        check("rst_rsp_rdata", 32'(rsp_rdata[k]), 0);
        check("rst_req_ready", 32'(req_ready[k]), 0);
    endtask

    // Present a request, wait (bounded) for acceptance, push its expectation.
    task automatic run_txn(input int k, input logic we, input logic [AW-1:0] addr,
                           input logic [7:0] wdata, input logic keep_valid, output int acc);
        int    guard = 0;
        item_t it;
        acc = -1;
        req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_valid[k] = 1'b1;
        do begin @(negedge clk); guard++; end while (!req_ready[k] && guard < 60);
        if (!req_ready[k]) begin
            check("accept_timeout", 32'(req_ready[k]), 1);
            req_valid[k] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        it.k = k; it.is_read = !we; it.addr = addr; it.wdata = wdata; it.acc_cyc = cyc;
        if (we) begin
            shadow[k][addr] = wdata;
            it.rdata = last_rd[k];
        end else begin
            it.rdata = shadow[k][addr];
            last_rd[k] = it.rdata;
        end
        sb.push_back(it);
        $display("inst=%0d accept %s addr=0x%03h wdata=0x%02h cyc=%0d",
                 k, we ? "WR" : "RD", addr, wdata, cyc);
        if (!keep_valid) req_valid[k] = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, pop the front expectation and compare.
    task automatic wait_rsp(input int k);
        item_t it;
        int    w = wait_of(k);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (rsp_valid[k]) begin
                it = sb.pop_front();
                check("latency", 32'(cyc - it.acc_cyc + 1), 32'(w + 2));
                check("rsp_rdata", 32'(rsp_rdata[k]), 32'(it.rdata));
                check("strobe_width", 32'(it.is_read ? oe_w[k] : we_w[k]), 32'(w));
                check("other_strobe_width", 32'(it.is_read ? we_w[k] : oe_w[k]), 0);
                check("ce_width", 32'(ce_cnt[k]), 32'(w + 2));
                check("bus_steady", 32'(bad[k]), 0);
                $display("inst=%0d response %s addr=0x%03h rdata=0x%02h exp=0x%02h",
                         k, it.is_read ? "RD" : "WR", it.addr, rsp_rdata[k], it.rdata);
                return;
            end
        end
        check("rsp_timeout", 32'(rsp_valid[k]), 1);
        if (sb.size() != 0) void'(sb.pop_front());
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int a1, a2;
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = 8'h00; last_rd[k] = 8'h00;
        end
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < N; k++) check_reset(k);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < N; k++) check("ready_after_reset", 32'(req_ready[k]), 1);

        // Single write then read-back on the WAIT_CYCLES=2 instance.
        run_txn(0, 1'b1, 10'h155, 8'hA5, 1'b0, a1);
        wait_rsp(0);
        check("sram_mem_0x155", 32'(g_dut[0].mem[341]), 32'h0A5);
        @(negedge clk); #1;
        check("idle_ce_n", 32'(ce_n[0]), 1);
        check("idle_address_kept", 32'(address[0]), 32'h155);
        check("idle_data_out_kept", 32'(data_out[0]), 32'hA5);
        check("idle_data_oe", 32'(data_oe[0]), 0);
        run_txn(0, 1'b0, 10'h155, 8'h00, 1'b0, a1);
        wait_rsp(0);

        // Back-to-back with req_valid held; request fields switch to the read
        // right after the first accept and must be ignored until IDLE.
        run_txn(0, 1'b1, 10'h3FF, 8'h5A, 1'b1, a1);
        req_we[0] = 1'b0; req_wdata[0] = 8'h77;
        wait_rsp(0);
        run_txn(0, 1'b0, 10'h3FF, 8'h77, 1'b0, a2);
        check("b2b_accept_spacing", 32'(a2 - a1), 5);
        wait_rsp(0);

        // Reset asserted during the first ACCESS cycle of a write.
        run_txn(0, 1'b1, 10'h2AA, 8'h3C, 1'b0, a1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check_reset(0);
        sb.delete();
        last_rd[0] = 8'h00;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_abort", 32'(req_ready[0]), 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("no_rsp_after_abort", 32'(rsp_valid[0]), 0);
        end

        // WAIT_CYCLES=1 and WAIT_CYCLES=15 instances, including address 0 and
        // the top address.
        for (int k = 1; k < N; k++) begin
            run_txn(k, 1'b1, 10'h000, 8'h11 + 8'(k), 1'b0, a1);
            wait_rsp(k);
            run_txn(k, 1'b1, 10'h3FF, 8'hC3 ^ 8'(k), 1'b0, a1);
            wait_rsp(k);
            run_txn(k, 1'b0, 10'h000, 8'h00, 1'b0, a1);
            wait_rsp(k);
            run_txn(k, 1'b0, 10'h3FF, 8'h00, 1'b0, a1);
            wait_rsp(k);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sram_bus_master.md
SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 65536: SRAM depth in bytes; address width AW = $clog2(MEM_SIZE).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2: strobe-active cycles per access; legal range 1..15.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, with the ports listed first as below.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  host request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  AW  byte address.
REQ-010 req_wdata  input  8  write data.
REQ-011 rsp_valid  output  1  one-cycle pulse marking completion of the accepted access.
REQ-012 rsp_rdata  output  8  read result, valid when rsp_valid is high after a read.
REQ-013 ce_n  output  1  SRAM chip enable, active low.
REQ-014 oe_n  output  1  SRAM output enable, active low.
REQ-015 we_n  output  1  SRAM write enable, active low.
REQ-016 address  output  AW  SRAM address.
REQ-017 data_out  output  8  write data driven toward the SRAM data_in pins.
REQ-018 data_in  input  8  SRAM data_out pins; high-Z outside read strobe.
REQ-019 data_oe  output  1  high when data_out is to be driven onto a shared bus.

Function
REQ-020 SHALL implement FSM states IDLE, SETUP, ACCESS, HOLD.
REQ-021 SHALL drive req_ready high only in IDLE.
REQ-022 SHALL accept a request on a rising edge with req_valid && req_ready, then latch req_we, req_addr and req_wdata.
REQ-023 SHALL ignore req_valid and all req_* changes in states other than IDLE.
REQ-024 Transitions:
- IDLE->SETUP on accept.
- SETUP->ACCESS after 1 cycle.
- ACCESS->HOLD after exactly WAIT_CYCLES cycles, tracked by an internal down-counter.
- HOLD->IDLE after 1 cycle.
REQ-025 SHALL make ce_n, oe_n, we_n, address, data_out, data_oe, rsp_valid and rsp_rdata registered outputs with no combinational path from inputs.
REQ-026 Strobe and bus levels per state:
- ce_n: low in SETUP, ACCESS and HOLD; high in IDLE.
- address: equals the latched address from SETUP through HOLD.
- we_n: low only in ACCESS, and only for writes.
- oe_n: low only in ACCESS, and only for reads.
- oe_n and we_n: never low simultaneously.
REQ-027 For writes, data_out SHALL equal the latched wdata and data_oe SHALL be high from SETUP through HOLD, covering setup and hold around the we_n rising edge.
REQ-028 For reads, data_oe SHALL stay 0.
REQ-029 For reads, rsp_rdata SHALL capture data_in on the clock edge ending the last ACCESS cycle.
REQ-030 rsp_rdata SHALL hold its value until the next read completes.
REQ-031 rsp_valid SHALL be high for exactly the HOLD cycle, for both reads and writes.
REQ-032 Latency: accept edge to rsp_valid high is WAIT_CYCLES+2 cycles.
REQ-033 Minimum request-to-request period is WAIT_CYCLES+3 cycles; back-to-back requests are accepted in the IDLE cycle after HOLD.
REQ-034 The address SHALL be used as-is with no wrap handling; the top address MEM_SIZE-1 SHALL be legal.
REQ-035 In IDLE, address and data_out SHALL retain their last values; only the strobes return high.

Reset
REQ-036 While rst_n is low, outputs SHALL be forced asynchronously to:
- state IDLE;
- ce_n = oe_n = we_n = 1;
- address = 0, data_out = 0, data_oe = 0;
- rsp_valid = 0, rsp_rdata = 0;
- req_ready = 0.
REQ-037 On the first rising edge after rst_n deasserts, req_ready SHALL be 1.
REQ-038 Reset asserted mid-transaction SHALL immediately deassert all strobes without waiting for a clock.
REQ-039 A transaction aborted by reset SHALL produce no rsp_valid, and that write's outcome is undefined.

Verification (MEM_SIZE=1024, WAIT_CYCLES=2, SRAM model attached)
REQ-040 Write addr 0x155, data 0xA5:
- ce_n low for 4 cycles.
- we_n low for exactly 2 cycles, with address = 0x155 and data_out = 0xA5 stable throughout.
- rsp_valid pulses 4 cycles after accept.
- SRAM location 0x155 = 0xA5.
REQ-041 Read 0x155 after REQ-040:
- oe_n low for 2 cycles, we_n stays 1, data_oe stays 0.
- rsp_valid with rsp_rdata = 0xA5.
REQ-042 Back-to-back: req_valid held high with write 0x3FF/0x5A then read 0x3FF.
- Second accept is exactly 5 cycles after the first.
- Read returns 0x5A.
- req_ready is low throughout each transaction.
REQ-043 Reset mid-write: assert rst_n low during the first ACCESS cycle.
- ce_n = we_n = 1 before the next edge.
- No rsp_valid occurs.
- req_ready = 1 one edge after release.
REQ-044 WAIT_CYCLES=1 and WAIT_CYCLES=15 builds:
- Strobe width is 1 and 15 cycles respectively.
- Latency is 3 and 17 cycles respectively.
- oe_n and we_n are never low together (assertion checked every cycle).
